wave_burst_sequencer: RTL
=========================

WAVE_BURST_SEQUENCER -- requirements
Module: wave_burst_sequencer

Interface
REQ-001 SHALL have parameter NSEG, default 4, number of program-table segments (power of 2).
REQ-002 SHALL have parameter LEN_W, default 8, width of the per-segment sample-count field.
REQ-003 SHALL use one clock and a synchronous active-high reset, sampled on posedge clk.
REQ-004 SHALL have ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start_i  in  1  pulse; begin sequence at segment 0
- stop_i  in  1  pulse; abort sequence
- n_seg_i  in  $clog2(NSEG)  last segment index to run
- cfg_we_i  in  1  table write strobe
- cfg_idx_i  in  $clog2(NSEG)  table write index
- cfg_sel_i  in  2  waveform select for the entry
- cfg_amp_i  in  INT_BITS  amplitude for the entry
- cfg_len_i  in  LEN_W  samples to generate for the entry
- gen_wr_en_i  in  1  generator sample-valid strobe
- fifo_full_i  in  1  downstream FIFO full
- gen_conf_o  out  1  generator configure enable (active-high)
- gen_en_low_o  out  1  generator run enable (active-low)
- gen_sel_o  out  2  waveform select to generator
- gen_amp_o  out  INT_BITS  amplitude to generator
- busy_o  out  1  sequence in progress
- done_o  out  1  one-cycle completion pulse
- seg_idx_o  out  $clog2(NSEG)  current segment index

Function
REQ-005 SHALL implement FSM states IDLE, LOAD, RUN, PAUSE, NEXT, DONE; all outputs are Moore decodes of registered state and registers.
REQ-006 IDLE: start_i=1 and stop_i=0 -> LOAD with seg_idx=0 and sample count=0; otherwise stay.
REQ-007 LOAD (exactly 1 cycle): gen_conf_o=1, gen_sel_o/gen_amp_o = table[seg_idx]; -> RUN; if table[seg_idx].len==0, -> NEXT instead (segment skipped).
REQ-008 RUN: gen_en_low_o=0; each gen_wr_en_i=1 increments count; gen_wr_en_i=1 with count==len-1 -> NEXT (takes priority over fifo_full_i); else fifo_full_i=1 -> PAUSE.
REQ-009 PAUSE: gen_en_low_o=1; gen_wr_en_i still counted (in-flight samples); count reaching len -> NEXT; fifo_full_i=0 -> RUN.
REQ-010 NEXT (1 cycle): count cleared; seg_idx==n_seg_i -> DONE, else seg_idx+1 -> LOAD.
REQ-011 DONE (1 cycle): done_o=1; -> IDLE.
REQ-012 busy_o=1 in every state except IDLE; gen_en_low_o=1 in every state except RUN.
REQ-013 gen_sel_o/gen_amp_o SHALL hold table[seg_idx] in all states except IDLE, where they are 0.
REQ-014 stop_i=1 in any non-IDLE state -> IDLE next cycle, no done_o pulse; stop_i wins over start_i.
REQ-015 start_i while busy_o=1 SHALL be ignored; cfg_we_i while busy_o=1 SHALL be ignored.
REQ-016 Latency: start_i at cycle t -> gen_conf_o=1 at t+1, gen_en_low_o=0 at t+2.
REQ-017 Counter LEN_W bits, never wraps; a len of all-ones SHALL produce 2^LEN_W-1 samples.

Reset
REQ-018 rst SHALL force state=IDLE, count=0, seg_idx_o=0, gen_conf_o=0, gen_en_low_o=1, gen_sel_o=0, gen_amp_o=0, busy_o=0, done_o=0, mid-operation included; table contents reset to 0.

Configuration
REQ-019 Macro WAVE_SEQ_LOOP_EN: when defined, adds input loop_i (1 bit); in NEXT with seg_idx==n_seg_i and loop_i=1 SHALL go to LOAD with seg_idx=0 (no DONE) until stop_i; when undefined, no loop_i port and REQ-010 applies unchanged.

Structure
REQ-020 seq_state_t enum and the table-entry struct (sel, amp, len) SHALL live in fifo_defines_pkg; INT_BITS comes from that package.
REQ-021 Program table SHALL be a sub-module wave_seq_table (NSEG-entry register file, one write port, one async read port).

Verification
REQ-022 Table {0:sel=1,amp=3,len=4}, n_seg_i=0, start -> conf pulse at t+1, 4 gen_wr_en_i counted, done_o one cycle, busy_o low after.
REQ-023 Three segments, lens 2/0/3, n_seg_i=2 -> seg 1 skipped (no conf for it), sel/amp track seg 0 then 2, done after 5 samples.
REQ-024 fifo_full_i=1 after 1 of 4 samples -> PAUSE, gen_en_low_o=1; one in-flight sample counted; release -> RUN, done after 4 total.
REQ-025 stop_i during RUN of seg 1 -> IDLE next cycle, no done_o, outputs at reset values; start_i same cycle as stop_i ignored.
REQ-026 rst mid-PAUSE -> all outputs at REQ-018 values next cycle; WAVE_SEQ_LOOP_EN build with loop_i=1 cycles seg 0->n_seg_i->0 without done_o.

Source files
------------

// File: rtl/fifo_defines_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fifo_defines_pkg
// Description : Shared types for wave_burst_sequencer (FSM states, table entry).
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_defines_pkg;

    localparam int INT_BITS    = 16;
    // Widest per-segment length any instance may use; entries carry this width.
    localparam int c_LEN_W_MAX = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } seq_state_t;

    typedef struct packed {
        logic [1:0]             sel;
        logic [INT_BITS-1:0]    amp;
        logic [c_LEN_W_MAX-1:0] len;
    } seq_entry_t;

endpackage
`default_nettype wire

// File: rtl/wave_burst_sequencer_if.sv
`default_nettype none
// ============================================================================
// Interface   : wave_burst_sequencer_if
// Description : Control, table-config and generator signals of the sequencer.
//               WAVE_SEQ_LOOP_EN adds the loop_i control.
// Revision    : 1.0 - initial release
// ============================================================================
interface wave_burst_sequencer_if #(
    parameter int NSEG  = 4,
    parameter int LEN_W = 8
);
    import fifo_defines_pkg::*;

    localparam int c_SEG_W = $clog2(NSEG);

    logic                start_i;
    logic                stop_i;
    logic [c_SEG_W-1:0]  n_seg_i;
    logic                cfg_we_i;
    logic [c_SEG_W-1:0]  cfg_idx_i;
    logic [1:0]          cfg_sel_i;
    logic [INT_BITS-1:0] cfg_amp_i;
    logic [LEN_W-1:0]    cfg_len_i;
    logic                gen_wr_en_i;
    logic                fifo_full_i;
`ifdef WAVE_SEQ_LOOP_EN
    logic                loop_i;
`endif
    logic                gen_conf_o;
    logic                gen_en_low_o;
    logic [1:0]          gen_sel_o;
    logic [INT_BITS-1:0] gen_amp_o;
    logic                busy_o;
    logic                done_o;
    logic [c_SEG_W-1:0]  seg_idx_o;

    modport slave (
`ifdef WAVE_SEQ_LOOP_EN
        input  loop_i,
`endif
        input  start_i, stop_i, n_seg_i, cfg_we_i, cfg_idx_i, cfg_sel_i,
               cfg_amp_i, cfg_len_i, gen_wr_en_i, fifo_full_i,
        output gen_conf_o, gen_en_low_o, gen_sel_o, gen_amp_o, busy_o,
               done_o, seg_idx_o
    );

    modport master (
`ifdef WAVE_SEQ_LOOP_EN
        output loop_i,
`endif
        output start_i, stop_i, n_seg_i, cfg_we_i, cfg_idx_i, cfg_sel_i,
               cfg_amp_i, cfg_len_i, gen_wr_en_i, fifo_full_i,
        input  gen_conf_o, gen_en_low_o, gen_sel_o, gen_amp_o, busy_o,
               done_o, seg_idx_o
    );

endinterface
`default_nettype wire

// File: rtl/wave_seq_table.sv
`default_nettype none
// ============================================================================
// Module      : wave_seq_table
// Description : NSEG-entry program table, one write port, one async read port.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_seq_table
    import fifo_defines_pkg::*;
#(
    parameter int NSEG  = 4,
    parameter int LEN_W = 8
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    i_we,
    input  wire logic [$clog2(NSEG)-1:0] i_wr_idx,
    input  wire logic [1:0]              i_wr_sel,
    input  wire logic [INT_BITS-1:0]     i_wr_amp,
    input  wire logic [LEN_W-1:0]        i_wr_len,
    input  wire logic [$clog2(NSEG)-1:0] i_rd_idx,
    output seq_entry_t                   o_rd_entry
);

    seq_entry_t r_tbl [NSEG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NSEG; i++) begin
                r_tbl[i] <= '0;
            end
        end else if (i_we) begin
            r_tbl[i_wr_idx] <= '{sel: i_wr_sel, amp: i_wr_amp, len: c_LEN_W_MAX'(i_wr_len)};
        end
    end

    assign o_rd_entry = r_tbl[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/wave_burst_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : wave_burst_sequencer
// Description : Steps a waveform generator through a programmed segment table,
//               counting generated samples per segment with FIFO back-pressure.
// Options     : WAVE_SEQ_LOOP_EN - loop_i restarts the table instead of DONE.
// Revision    : 1.0 - initial release
// ============================================================================
module wave_burst_sequencer
    import fifo_defines_pkg::*;
#(
    parameter int NSEG  = 4,
    parameter int LEN_W = 8
) (
    input wire logic              clk,
    input wire logic              rst,
    wave_burst_sequencer_if.slave bus
);

    localparam int c_SEG_W = $clog2(NSEG);

    seq_state_t              r_state;
    seq_state_t              w_state_nxt;
    logic [LEN_W-1:0]        r_cnt;
    logic [LEN_W-1:0]        w_cnt_nxt;
    logic [c_SEG_W-1:0]      r_seg;
    logic [c_SEG_W-1:0]      w_seg_nxt;
    seq_entry_t              w_entry;
    logic                    w_cfg_we;
    logic                    w_idle;
    logic                    w_len_zero;
    logic                    w_last;
    logic                    w_loop;
    logic [c_LEN_W_MAX-1:0]  w_len_m1;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_cfg_we = bus.cfg_we_i && w_idle;

    wave_seq_table #(
        .NSEG  (NSEG),
        .LEN_W (LEN_W)
    ) u_table (
        .clk        (clk),
        .rst        (rst),
        .i_we       (w_cfg_we),
        .i_wr_idx   (bus.cfg_idx_i),
        .i_wr_sel   (bus.cfg_sel_i),
        .i_wr_amp   (bus.cfg_amp_i),
        .i_wr_len   (bus.cfg_len_i),
        .i_rd_idx   (r_seg),
        .o_rd_entry (w_entry)
    );

    // len==0 never reaches RUN/PAUSE, so len-1 cannot underflow where used.
    assign w_len_zero = (w_entry.len == '0);
    assign w_len_m1   = w_entry.len - c_LEN_W_MAX'(1);
    assign w_last     = (c_LEN_W_MAX'(r_cnt) == w_len_m1);

`ifdef WAVE_SEQ_LOOP_EN
    assign w_loop = bus.loop_i;
`else
    assign w_loop = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_seg   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_seg   <= w_seg_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_seg_nxt   = r_seg;
        if (!w_idle && bus.stop_i) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_seg_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start_i && !bus.stop_i) begin
                        w_state_nxt = ST_LOAD;
                        w_cnt_nxt   = '0;
                        w_seg_nxt   = '0;
                    end
                end
                ST_LOAD: begin
                    w_state_nxt = w_len_zero ? ST_NEXT : ST_RUN;
                end
                ST_RUN: begin
                    if (bus.gen_wr_en_i) begin
                        w_cnt_nxt = r_cnt + LEN_W'(1);
                    end
                    if (bus.gen_wr_en_i && w_last) begin
                        w_state_nxt = ST_NEXT;
                    end else if (bus.fifo_full_i) begin
                        w_state_nxt = ST_PAUSE;
                    end
                end
                ST_PAUSE: begin
                    // Samples already in flight when the FIFO filled still count.
                    if (bus.gen_wr_en_i) begin
                        w_cnt_nxt = r_cnt + LEN_W'(1);
                    end
                    if (bus.gen_wr_en_i && w_last) begin
                        w_state_nxt = ST_NEXT;
                    end else if (!bus.fifo_full_i) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_NEXT: begin
                    w_cnt_nxt = '0;
                    if (r_seg == bus.n_seg_i) begin
                        if (w_loop) begin
                            w_state_nxt = ST_LOAD;
                            w_seg_nxt   = '0;
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_state_nxt = ST_LOAD;
                        w_seg_nxt   = r_seg + c_SEG_W'(1);
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_seg_nxt   = '0;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_seg_nxt   = '0;
                end
            endcase
        end
    end

    // A zero-length segment passes through LOAD without configuring the generator.
    assign bus.gen_conf_o   = (r_state == ST_LOAD) && !w_len_zero;
    assign bus.gen_en_low_o = (r_state != ST_RUN);
    assign bus.busy_o       = !w_idle;
    assign bus.done_o       = (r_state == ST_DONE);
    assign bus.seg_idx_o    = r_seg;
    assign bus.gen_sel_o    = w_idle ? 2'b00 : w_entry.sel;
    assign bus.gen_amp_o    = w_idle ? '0    : w_entry.amp;

endmodule
`default_nettype wire
